// File: rtl/inst_fetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer_pkg
//   Shared types and constants for the fetch-to-decode instruction buffer.
//   - IFB_ADDR_WIDTH / IFB_INST_WIDTH : global pc and instruction widths
//   - IFB_DEFAULT_DEPTH               : default number of queued packets
//   - fetch_pkt_t                     : one fetched instruction packet
// -----------------------------------------------------------------------------
package inst_fetch_buffer_pkg;

  localparam int unsigned IFB_ADDR_WIDTH    = 32;
  localparam int unsigned IFB_INST_WIDTH    = 32;
  localparam int unsigned IFB_DEFAULT_DEPTH = 4;

  // Packet as delivered by fetch: pc, instruction word and prediction info.
  typedef struct packed {
    logic [IFB_ADDR_WIDTH-1:0] pc;
    logic [IFB_INST_WIDTH-1:0] inst;
    logic                      branch;
    logic [IFB_ADDR_WIDTH-1:0] branch_addr;
  } fetch_pkt_t;

  // Build a packet from its individual fields.
  function automatic fetch_pkt_t make_fetch_pkt(
    input logic [IFB_ADDR_WIDTH-1:0] pc,
    input logic [IFB_INST_WIDTH-1:0] inst,
    input logic                      branch,
    input logic [IFB_ADDR_WIDTH-1:0] branch_addr
  );
    fetch_pkt_t pkt;
    pkt.pc          = pc;
    pkt.inst        = inst;
    pkt.branch      = branch;
    pkt.branch_addr = branch_addr;
    return pkt;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//   Pointer / occupancy bookkeeping for a synchronous circular FIFO. The
//   storage itself lives in the parent; this block only says where to write,
//   where to read and how full the queue is.
//
//   Ports
//     clk       : clock, all updates on the rising edge
//     rst       : synchronous active-low reset
//     i_push    : write one entry at o_wr_idx this cycle
//     i_pop     : retire the entry at o_rd_idx this cycle
//     i_flush   : drop all entries (beats push and pop)
//     o_wr_idx  : slot the next push lands in
//     o_rd_idx  : slot holding the current head
//     o_count   : occupancy, 0..DEPTH
//     o_full    : occupancy == DEPTH
//     o_empty   : occupancy == 0
// -----------------------------------------------------------------------------
module sync_fifo_ctrl
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IFB_DEFAULT_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [PTR_W-1:0] o_wr_idx,
  output logic [PTR_W-1:0] o_rd_idx,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_wr_ptr_d;
  logic [PTR_W-1:0] w_rd_ptr_d;
  logic [CNT_W-1:0] w_count_d;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // Defensive gating: a push into a full queue or a pop from an empty one
  // would corrupt the pointers, so they are ignored here as well.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    if (i_flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so +1 wraps DEPTH-1 -> 0.
      if (w_push_ok) w_wr_ptr_d = r_wr_ptr + 1'b1;
      if (w_pop_ok)  w_rd_ptr_d = r_rd_ptr + 1'b1;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   w_count_d = r_count + CNT_W'(1);
        2'b01:   w_count_d = r_count - CNT_W'(1);
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  assign o_wr_idx = r_wr_ptr;
  assign o_rd_idx = r_rd_ptr;
  assign o_count  = r_count;

endmodule

// File: rtl/inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer
//   Show-ahead packet queue between the fetch and decode stages. Fetch pushes
//   {pc, inst, branch, branch_addr} on in_valid && in_ready; decode sees the
//   oldest packet on out_* and retires it with out_ready. flush empties the
//   queue in one cycle.
//
//   Ports
//     clk, rst                 : clock, synchronous active-low reset
//     in_valid / in_ready      : fetch-side handshake (in_ready is registered
//                                state only, never a function of out_ready)
//     in_pc, in_inst,
//     in_branch, in_branch_addr: packet from fetch
//     flush                    : pipeline redirect, discard everything
//     out_valid / out_ready    : decode-side handshake
//     out_pc, out_inst,
//     out_branch,
//     out_branch_addr          : head packet, all zero while empty
//     count                    : current occupancy
// -----------------------------------------------------------------------------
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = IFB_DEFAULT_DEPTH,
  parameter int unsigned ADDR_WIDTH = IFB_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH = IFB_INST_WIDTH,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [INST_WIDTH-1:0] in_inst,
  input  logic                  in_branch,
  input  logic [ADDR_WIDTH-1:0] in_branch_addr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  out_branch,
  output logic [ADDR_WIDTH-1:0] out_branch_addr,
  output logic [CNT_W-1:0]      count
);

  // Packet storage; pointers are reset in the controller, contents are not.
  fetch_pkt_t       r_mem [DEPTH];

  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_rd_idx;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  fetch_pkt_t       w_in_pkt;
  fetch_pkt_t       w_head;

  // Handshake qualifiers. Flush suppresses both sides of the same cycle.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  sync_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (flush),
    .o_wr_idx (w_wr_idx),
    .o_rd_idx (w_rd_idx),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign w_in_pkt = make_fetch_pkt(in_pc, in_inst, in_branch, in_branch_addr);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= w_in_pkt;
    end
  end

  // Show-ahead head; forced to zero when empty so stale entries never leak.
  always_comb begin
    w_head = '0;
    if (!w_empty) begin
      w_head = r_mem[w_rd_idx];
    end
  end

  assign out_pc          = w_head.pc;
  assign out_inst        = w_head.inst;
  assign out_branch      = w_head.branch;
  assign out_branch_addr = w_head.branch_addr;
  assign count           = w_count;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE  = 32'h1C00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
    logic [31:0] ba;
  } pkt_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             in_branch;
  logic [31:0]      in_branch_addr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_branch;
  logic [31:0]      out_branch_addr;
  logic [CNT_W-1:0] count;

  int   checks;
  int   errors;
  bit   inv_en;
  pkt_t model_q[$];  // packets the buffer should hold, oldest first
  pkt_t exp_q[$];    // packets decode should have accepted, in order
  pkt_t seen_q[$];   // packets decode actually accepted

  inst_fetch_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (32),
    .INST_WIDTH (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_inst         (in_inst),
    .in_branch       (in_branch),
    .in_branch_addr  (in_branch_addr),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_branch      (out_branch),
    .out_branch_addr (out_branch_addr),
    .count           (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
    $fatal(1);
  end

  // Structural invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (int'(count) > int'(DEPTH) || (count == 0 && out_valid) ||
          (int'(count) == int'(DEPTH) && in_ready)) begin
        errors++;
        $display("FAIL invariant: count=%0d out_valid=%0b in_ready=%0b required count<=%0d",
                 count, out_valid, in_ready, DEPTH);
      end
    end
  end

  // Advance one clock and update the queue model from the handshake rules.
  task automatic tick();
    pkt_t p;
    bit   rst_s, fl_s, do_push, do_pop;
    rst_s   = rst;
    fl_s    = flush;
    do_push = rst_s && !fl_s && in_valid && (model_q.size() < int'(DEPTH));
    do_pop  = rst_s && !fl_s && out_ready && (model_q.size() != 0);
    p       = '{pc: in_pc, inst: in_inst, br: in_branch, ba: in_branch_addr};
    if (do_pop) begin
      seen_q.push_back('{pc: out_pc, inst: out_inst, br: out_branch, ba: out_branch_addr});
      exp_q.push_back(model_q[0]);
    end
    @(posedge clk);
    #1;
    if (!rst_s || fl_s) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(p);
    end
  endtask

  task automatic drive_pkt(input logic [31:0] pc, input logic [31:0] inst,
                           input logic br, input logic [31:0] ba);
    in_pc          = pc;
    in_inst        = inst;
    in_branch      = br;
    in_branch_addr = ba;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 2; i++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%0b in_ready=%0b count=%0d required 0 1 0",
               out_valid, in_ready, count);
    end
    checks++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0 || out_branch !== 1'b0 ||
        out_branch_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_fields: pc=%h inst=%h br=%0b ba=%h required all zero",
               out_pc, out_inst, out_branch, out_branch_addr);
    end
    inv_en = 1'b1;
  endtask

  task automatic test_single_pass();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_pkt(BASE, 32'h0280_0000, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== BASE || out_inst !== 32'h0280_0000 ||
        out_branch !== 1'b0 || out_branch_addr !== 32'h0 || count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL single_head: v=%0b pc=%h inst=%h br=%0b cnt=%0d required 1 %h 02800000 0 1",
               out_valid, out_pc, out_inst, out_branch, count, BASE);
    end
    tick();
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: count=%0d out_valid=%0b required 0 0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    int s;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_pkt(BASE + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'(i & 1), 32'h2000_0000 + 32'(i));
      tick();
    end
    checks++;
    if (in_ready !== 1'b0 || count !== CNT_W'(4)) begin
      errors++;
      $display("FAIL fill_full: in_ready=%0b count=%0d required 0 4", in_ready, count);
    end
    drive_pkt(BASE + 32'h10, 32'hA000_0004, 1'b1, 32'h2000_0004);
    tick();
    checks++;
    if (count !== CNT_W'(4) || out_pc !== BASE) begin
      errors++;
      $display("FAIL fill_hold: count=%0d head=%h required 4 %h", count, out_pc, BASE);
    end
    s = seen_q.size();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || count !== CNT_W'(3) || out_pc !== BASE + 32'h4) begin
      errors++;
      $display("FAIL fill_pop: in_ready=%0b count=%0d head=%h required 1 3 %h",
               in_ready, count, out_pc, BASE + 32'h4);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== CNT_W'(4)) begin
      errors++;
      $display("FAIL fill_accept5: count=%0d required 4", count);
    end
    drain();
    checks++;
    if (seen_q.size() - s != 5) begin
      errors++;
      $display("FAIL fill_order_len: got=%0d required 5", seen_q.size() - s);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (seen_q[s + k].pc !== BASE + 32'(4 * k)) begin
          errors++;
          $display("FAIL fill_order[%0d]: pc=%h required %h", k, seen_q[s + k].pc,
                   BASE + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int s, idx, cyc;
    logic [31:0] wbase;
    wbase = 32'h1C00_1000;
    s     = seen_q.size();
    idx   = 0;
    cyc   = 0;
    while ((idx < 10 || model_q.size() != 0) && cyc < 200) begin
      in_valid  = (idx < 10);
      out_ready = ((cyc % 2) == 0);
      drive_pkt(wbase + 32'(4 * idx), 32'($urandom), 1'b0, 32'h0);
      if (in_valid && model_q.size() < int'(DEPTH)) begin
        tick();
        idx++;
      end else begin
        tick();
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (cyc >= 200 || seen_q.size() - s != 10) begin
      errors++;
      $display("FAIL wrap_len: popped=%0d cycles=%0d required 10 within 200",
               seen_q.size() - s, cyc);
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (seen_q[s + k].pc !== wbase + 32'(4 * k)) begin
          errors++;
          $display("FAIL wrap_order[%0d]: pc=%h required %h", k, seen_q[s + k].pc,
                   wbase + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_flush();
    int s;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_pkt(32'h3000_0000 + 32'(4 * i), 32'h1, 1'b0, 32'h0);
      tick();
    end
    checks++;
    if (count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL flush_setup: count=%0d required 3", count);
    end
    s = seen_q.size();
    flush     = 1'b1;
    out_ready = 1'b1;
    drive_pkt(32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_0004);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: count=%0d out_valid=%0b in_ready=%0b required 0 0 1",
               count, out_valid, in_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || seen_q.size() != s) begin
      errors++;
      $display("FAIL flush_leak: out_valid=%0b pops=%0d required 0 0", out_valid,
               seen_q.size() - s);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_pkt(32'h4000_0000 + 32'(4 * i), 32'h2, 1'b0, 32'h0);
      tick();
    end
    checks++;
    if (count !== CNT_W'(2)) begin
      errors++;
      $display("FAIL rstmid_setup: count=%0d required 2", count);
    end
    rst = 1'b0;
    drive_pkt(32'h0BAD_0000, 32'h3, 1'b0, 32'h0);
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: count=%0d out_valid=%0b required 0 0", count, out_valid);
    end
    in_valid = 1'b1;
    drive_pkt(32'h5000_0040, 32'h1234_5678, 1'b1, 32'h5000_0100);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h5000_0040 || out_inst !== 32'h1234_5678 ||
        out_branch !== 1'b1 || out_branch_addr !== 32'h5000_0100 || count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL rstmid_head: v=%0b pc=%h inst=%h br=%0b ba=%h cnt=%0d required 1 50000040",
               out_valid, out_pc, out_inst, out_branch, out_branch_addr, count);
    end
    drain();
  endtask

  task automatic test_random();
    pkt_t head, want;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      drive_pkt(32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), 32'($urandom));
      #1;
      want = (model_q.size() != 0) ? model_q[0] : '0;
      head = '{pc: out_pc, inst: out_inst, br: out_branch, ba: out_branch_addr};
      checks++;
      if (out_valid !== (model_q.size() != 0) || in_ready !== (model_q.size() < int'(DEPTH)) ||
          count !== CNT_W'(model_q.size()) || head !== want) begin
        errors++;
        $display("FAIL random[%0d]: v=%0b rdy=%0b cnt=%0d head=%h required v=%0b cnt=%0d head=%h",
                 c, out_valid, in_ready, count, head, model_q.size() != 0, model_q.size(), want);
      end
      tick();
    end
    flush = 1'b0;
    drain();
  endtask

  task automatic test_global_order();
    checks++;
    if (seen_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL order_len: got=%0d required %0d", seen_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < seen_q.size(); k++) begin
        checks++;
        if (seen_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL order[%0d]: got=%h required %h", k, seen_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    inv_en    = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    drive_pkt(32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    test_reset();
    test_single_pass();
    test_fill_backpressure();
    test_wrap();
    test_flush();
    test_reset_midstream();
    test_random();
    test_global_order();
    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
